id_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the decode stage of the 5-stage RV32I pipeline. It tracks the destination register of every in-flight instruction in EX, MEM and WB. From that it drives the decode operand-mux selects (rD1_sel/rD2_sel) and detects load-use hazards, stalling PC and IF/ID and inserting an EX bubble. It also converts a decode-stage redirect (pc_sel) into an IF/ID flush.

---
 rtl/id_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and forwarding controller for the 5-stage RV32I pipeline.
// Tracks rd of EX/MEM/WB, drives operand-mux selects, load-use stalls and redirect flushes.
module id_hazard_ctrl #(
    parameter bit MEM_LOAD_FWD = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             id_rf_we,
    input  logic             pc_sel,
    output logic [1:0]       rD1_sel,
    output logic [1:0]       rD2_sel,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       ld;
    } stage_rec_t;

    logic [6:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             useRs1;
    logic             useRs2;
    stage_rec_t       decRec;
    stage_rec_t       exD;
    stage_rec_t       exQ;
    stage_rec_t       memQ;
    stage_rec_t       wbQ;
    logic [CNT_W-1:0] cntD;
    logic [CNT_W-1:0] cntQ;
    logic             exHit1;
    logic             exHit2;
    logic             memHit1;
    logic             memHit2;
    logic             wbHit1;
    logic             wbHit2;
    logic             stall;
    logic             unusedInstBits;

    assign opcode         = id_inst[6:0];
    assign rs1            = id_inst[19:15];
    assign rs2            = id_inst[24:20];
    assign unusedInstBits = ^{id_inst[31:25], id_inst[14:12]};

    always_comb begin
        useRs1 = 1'b0;
        useRs2 = 1'b0;
        case (opcode)
            OP_OP, OP_STORE, OP_BRANCH: begin
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: useRs1 = 1'b1;
            default: ;
        endcase
    end

    // rd == x0 is folded into 'we' so a write to x0 is never tracked as a producer.
    always_comb begin
        decRec.v  = id_valid;
        decRec.we = id_rf_we && (id_inst[11:7] != 5'd0);
        decRec.rd = id_inst[11:7];
        decRec.ld = (opcode == OP_LOAD);
    end

    function automatic logic srcHit(input stage_rec_t s, input logic [4:0] r, input logic used);
        return used && s.v && s.we && (s.rd == r) && (r != 5'd0);
    endfunction

    assign exHit1  = srcHit(exQ,  rs1, useRs1);
    assign exHit2  = srcHit(exQ,  rs2, useRs2);
    assign memHit1 = srcHit(memQ, rs1, useRs1);
    assign memHit2 = srcHit(memQ, rs2, useRs2);
    assign wbHit1  = srcHit(wbQ,  rs1, useRs1);
    assign wbHit2  = srcHit(wbQ,  rs2, useRs2);

    always_comb begin
        rD1_sel = SEL_RF;
        if (exHit1)       rD1_sel = SEL_EX;
        else if (memHit1) rD1_sel = SEL_MEM;
        else if (wbHit1)  rD1_sel = SEL_WB;

        rD2_sel = SEL_RF;
        if (exHit2)       rD2_sel = SEL_EX;
        else if (memHit2) rD2_sel = SEL_MEM;
        else if (wbHit2)  rD2_sel = SEL_WB;
    end

    // Without MEM load forwarding the load must reach WB before its consumer can proceed.
    assign stall = ((exHit1 || exHit2) && exQ.ld)
                || (!MEM_LOAD_FWD && (memHit1 || memHit2) && memQ.ld);

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = pc_sel && id_valid && !stall;
    assign stall_cnt   = cntQ;

    always_comb begin
        exD  = stall ? '0 : decRec;
        cntD = cntQ;
        if (stall && (cntQ != '1)) cntD = cntQ + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exQ  <= '0;
            memQ <= '0;
            wbQ  <= '0;
            cntQ <= '0;
        end else begin
            exQ  <= exD;
            memQ <= exQ;
            wbQ  <= memQ;
            cntQ <= cntD;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed instruction sequences push hand-computed
// expectations; a negedge monitor pops and compares. Instance B has no MEM load forwarding.
module tb_id_hazard_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        aValid, aWe, aPcSel;
    logic [31:0] aInst;
    logic [1:0]  aSel1, aSel2;
    logic        aPcStall, aIfidStall, aFlush, aBubble;
    logic [15:0] aCnt;

    logic        bValid, bWe, bPcSel;
    logic [31:0] bInst;
    logic [1:0]  bSel1, bSel2;
    logic        bPcStall, bIfidStall, bFlush, bBubble;
    logic [3:0]  bCnt;

    id_hazard_ctrl #(.MEM_LOAD_FWD(1'b1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(aValid), .id_inst(aInst), .id_rf_we(aWe),
        .pc_sel(aPcSel), .rD1_sel(aSel1), .rD2_sel(aSel2), .pc_stall(aPcStall),
        .ifid_stall(aIfidStall), .ifid_flush(aFlush), .idex_bubble(aBubble), .stall_cnt(aCnt)
    );

    id_hazard_ctrl #(.MEM_LOAD_FWD(1'b0), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(bValid), .id_inst(bInst), .id_rf_we(bWe),
        .pc_sel(bPcSel), .rD1_sel(bSel1), .rD2_sel(bSel2), .pc_stall(bPcStall),
        .ifid_stall(bIfidStall), .ifid_flush(bFlush), .idex_bubble(bBubble), .stall_cnt(bCnt)
    );

    typedef struct {
        int         tgt;
        string      name;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       stall;
        logic       flush;
        int         cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
        end
    endtask

    task automatic pushExp(input int tgt, input string name, input logic [1:0] s1,
                           input logic [1:0] s2, input logic st, input logic fl, input int cnt);
        exp_t e;
        e.tgt = tgt; e.name = name; e.sel1 = s1; e.sel2 = s2;
        e.stall = st; e.flush = fl; e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int tgt, input logic valid, input logic [31:0] inst,
                                 input logic we, input logic pcSel, input bit doCheck,
                                 input string name, input logic [1:0] s1, input logic [1:0] s2,
                                 input logic st, input logic fl, input int cnt);
        @(posedge clk);
        #1;
        if (tgt == 0) begin
            aValid = valid; aInst = inst; aWe = we; aPcSel = pcSel;
        end else begin
            bValid = valid; bInst = inst; bWe = we; bPcSel = pcSel;
        end
        if (doCheck) pushExp(tgt, name, s1, s2, st, fl, cnt);
    endtask

    task automatic idle(input int tgt, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tgt, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "", 2'd0, 2'd0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: every negedge, pop one expectation if present and compare all outputs.
    initial begin
        exp_t        e;
        logic [1:0]  s1, s2;
        logic        ps, is, bb, fl;
        logic [31:0] cv;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.tgt == 0) begin
                    s1 = aSel1; s2 = aSel2; ps = aPcStall; is = aIfidStall;
                    bb = aBubble; fl = aFlush; cv = 32'(aCnt);
                end else begin
                    s1 = bSel1; s2 = bSel2; ps = bPcStall; is = bIfidStall;
                    bb = bBubble; fl = bFlush; cv = 32'(bCnt);
                end
                checkOutput(e.name, "rD1_sel",     32'(s1), 32'(e.sel1));
                checkOutput(e.name, "rD2_sel",     32'(s2), 32'(e.sel2));
                checkOutput(e.name, "pc_stall",    32'(ps), 32'(e.stall));
                checkOutput(e.name, "ifid_stall",  32'(is), 32'(e.stall));
                checkOutput(e.name, "idex_bubble", 32'(bb), 32'(e.stall));
                checkOutput(e.name, "ifid_flush",  32'(fl), 32'(e.flush));
                checkOutput(e.name, "stall_cnt",   cv,      32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        aValid = 0; aInst = 0; aWe = 0; aPcSel = 0;
        bValid = 0; bInst = 0; bWe = 0; bPcSel = 0;
        pushExp(0, "reset_a", 2'd0, 2'd0, 1'b0, 1'b0, 0);
        pushExp(1, "reset_b", 2'd0, 2'd0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] back-to-back ALU dependency");
        applyStimulus(0, 1, mk(OP_R, 5, 1, 2), 1, 0, 1, "t1_add", 0, 0, 0, 0, 0);
        applyStimulus(0, 1, mk(OP_R, 6, 5, 3), 1, 0, 1, "t1_sub", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, mk(OP_R, 7, 5, 0), 1, 0, 1, "t1_or",  2, 0, 0, 0, 0);
        idle(0, 3);

        $display("[TB] load-use with MEM forwarding");
        applyStimulus(0, 1, mk(OP_LD, 8, 1, 0), 1, 0, 1, "t2_lw",    0, 0, 0, 0, 0);
        applyStimulus(0, 1, mk(OP_R, 9, 8, 8),  1, 0, 1, "t2_stall", 1, 1, 1, 0, 0);
        applyStimulus(0, 1, mk(OP_R, 9, 8, 8),  1, 0, 1, "t2_fwd",   2, 2, 0, 0, 1);
        applyStimulus(0, 0, 32'd0,              0, 0, 1, "t2_cnt",   0, 0, 0, 0, 1);
        idle(0, 2);

        $display("[TB] priority and x0");
        applyStimulus(0, 1, mk(OP_I, 4, 0, 1),   1, 0, 1, "t3_a1",   0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_I, 4, 0, 2),   1, 0, 1, "t3_a2",   0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_R, 10, 4, 4),  1, 0, 1, "t3_add",  1, 1, 0, 0, 1);
        idle(0, 3);
        applyStimulus(0, 1, mk(OP_I, 0, 0, 5),   1, 0, 1, "t3_x0w",  0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_R, 11, 0, 0),  1, 0, 1, "t3_x0r",  0, 0, 0, 0, 1);
        idle(0, 3);
        applyStimulus(0, 1, mk(OP_LD, 0, 1, 0),  1, 0, 1, "t3_lx0",  0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_R, 11, 0, 0),  1, 0, 1, "t3_lx0u", 0, 0, 0, 0, 1);
        idle(0, 3);

        $display("[TB] WB forwarding, write-enable, valid and source-use gating");
        applyStimulus(0, 1, mk(OP_R, 13, 1, 2),  1, 0, 1, "e1_prod", 0, 0, 0, 0, 1);
        idle(0, 2);
        applyStimulus(0, 1, mk(OP_R, 12, 13, 13), 1, 0, 1, "e1_wb",  3, 3, 0, 0, 1);
        idle(0, 3);
        applyStimulus(0, 1, mk(OP_R, 5, 1, 2),   0, 0, 1, "e2_nowe", 0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_R, 14, 5, 5),  1, 0, 1, "e2_use",  0, 0, 0, 0, 1);
        idle(0, 3);
        applyStimulus(0, 0, mk(OP_R, 6, 1, 2),   1, 0, 1, "e3_inval", 0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_R, 14, 6, 6),  1, 0, 1, "e3_use",   0, 0, 0, 0, 1);
        idle(0, 3);
        applyStimulus(0, 1, mk(OP_R, 7, 1, 2),   1, 0, 1, "e4_prod", 0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_LUI, 15, 7, 7), 1, 0, 1, "e4_lui", 0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_I, 16, 7, 7),  1, 0, 1, "e4_addi", 2, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_ST, 0, 1, 7),  0, 0, 1, "e4_sw",   0, 3, 0, 0, 1);
        idle(0, 3);

        $display("[TB] branch on load");
        applyStimulus(0, 1, mk(OP_LD, 3, 1, 0), 1, 0, 1, "t4_lw",    0, 0, 0, 0, 1);
        applyStimulus(0, 1, mk(OP_BR, 0, 3, 0), 0, 1, 1, "t4_stall", 1, 0, 1, 0, 1);
        applyStimulus(0, 1, mk(OP_BR, 0, 3, 0), 0, 1, 1, "t4_redir", 2, 0, 0, 1, 2);
        applyStimulus(0, 0, 32'd0,              0, 1, 1, "t4_nv",    0, 0, 0, 0, 2);
        idle(0, 2);

        $display("[TB] reset during a load-use stall");
        applyStimulus(0, 1, mk(OP_LD, 8, 1, 0), 1, 0, 1, "t5_lw", 0, 0, 0, 0, 2);
        applyStimulus(0, 1, mk(OP_R, 9, 8, 8),  1, 0, 0, "", 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        pushExp(0, "t5_rst", 2'd0, 2'd0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        aValid = 0; aInst = 0; aWe = 0; aPcSel = 0;
        applyStimulus(0, 1, mk(OP_R, 9, 8, 8), 1, 0, 1, "t5_post", 0, 0, 0, 0, 0);
        idle(0, 3);

        $display("[TB] load-use without MEM forwarding");
        applyStimulus(1, 1, mk(OP_LD, 8, 1, 0), 1, 0, 1, "b_lw",  0, 0, 0, 0, 0);
        applyStimulus(1, 1, mk(OP_R, 9, 8, 8),  1, 0, 1, "b_st1", 1, 1, 1, 0, 0);
        applyStimulus(1, 1, mk(OP_R, 9, 8, 8),  1, 0, 1, "b_st2", 2, 2, 1, 0, 1);
        applyStimulus(1, 1, mk(OP_R, 9, 8, 8),  1, 0, 1, "b_wb",  3, 3, 0, 0, 2);
        applyStimulus(1, 0, 32'd0,              0, 0, 1, "b_cnt", 0, 0, 0, 0, 2);
        idle(1, 2);

        $display("[TB] stall counter saturation");
        for (int it = 0; it < 10; it++) begin
            applyStimulus(1, 1, mk(OP_LD, 8, 1, 0), 1, 0, 0, "", 0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++)
                applyStimulus(1, 1, mk(OP_R, 9, 8, 8), 1, 0, 0, "", 0, 0, 0, 0, 0);
            if (it == 5) applyStimulus(1, 0, 32'd0, 0, 0, 1, "b_cnt14", 0, 0, 0, 0, 14);
        end
        applyStimulus(1, 0, 32'd0, 0, 0, 1, "b_sat", 0, 0, 0, 0, 15);

        repeat (2) @(posedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
